// File: rtl/layer_mem_arbiter_pkg.sv
// lm_arb_pkg: shared types and constants for the layer-memory arbiter.
// Imported by the interface, the read-tag pipe and the arbiter top.
package lm_arb_pkg;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 13;

  localparam logic CSEL_L0 = 1'b0;
  localparam logic CSEL_L1 = 1'b1;

  typedef logic req_id_t;

  typedef struct packed {
    logic    valid;
    req_id_t owner;
  } rd_tag_t;

  typedef enum logic {
    ARB_IDLE,
    ARB_ISSUE
  } arb_state_e;

  function automatic logic [15:0] sat_inc(
    input logic [15:0] v
  );
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/layer_mem_arbiter_if.sv
// layer_mem_arbiter_if: request/grant/read-return bundle for the two
// layer-memory requesters (0 = conv write-back, 1 = max-pool).
interface layer_mem_arbiter_if;
  import lm_arb_pkg::*;

  logic              req0;
  logic              req1;
  logic              we0;
  logic              we1;
  logic              sel0;
  logic              sel1;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata0;
  logic [DATA_W-1:0] wdata1;
  logic              gnt0;
  logic              gnt1;
  logic              rvalid0;
  logic              rvalid1;
  logic [DATA_W-1:0] rdata0;
  logic [DATA_W-1:0] rdata1;

  modport master (
    output req0, req1, we0, we1,
    output sel0, sel1, addr0, addr1,
    output wdata0, wdata1,
    input  gnt0, gnt1, rvalid0, rvalid1,
    input  rdata0, rdata1
  );

  modport slave (
    input  req0, req1, we0, we1,
    input  sel0, sel1, addr0, addr1,
    input  wdata0, wdata1,
    output gnt0, gnt1, rvalid0, rvalid1,
    output rdata0, rdata1
  );

endinterface

// File: rtl/layer_mem_arbiter_rd_tag_pipe.sv
// lm_rd_tag_pipe: fixed-depth shift register carrying read tags
// alongside the memory read latency; cleared by async reset.
module lm_rd_tag_pipe
  import lm_arb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic    clk,
  input  logic    reset,
  input  rd_tag_t tag_in,
  output rd_tag_t tag_out
);

  rd_tag_t stage_q [DEPTH];

  // shift tags one stage per cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= tag_in;
      for (int i = 1; i < DEPTH; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign tag_out = stage_q[DEPTH-1];

endmodule

// File: rtl/layer_mem_arbiter.sv
// layer_mem_arbiter: round-robin share of the layer-memory port.
// Optional saturating statistics counters: LM_ARB_STATS_EN.
module layer_mem_arbiter
  import lm_arb_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  layer_mem_arbiter_if.slave rq,
  output logic               cwr,
  output logic               crd,
  output logic [ADDR_W-1:0]  caddr_wr,
  output logic [ADDR_W-1:0]  caddr_rd,
  output logic [DATA_W-1:0]  cdata_wr,
  input  logic [DATA_W-1:0]  cdata_rd,
  output logic               csel,
  output logic [15:0]        grant_cnt0,
  output logic [15:0]        grant_cnt1,
  output logic [15:0]        conflict_cnt
);

  arb_state_e        state_q;
  arb_state_e        state_d;
  req_id_t           last_q;
  req_id_t           win;
  logic              gnt0;
  logic              gnt1;
  logic              xfer;
  logic              both;
  logic              only0;
  logic              only1;
  logic              we_q;
  logic              s_we;
  logic              s_sel;
  logic [ADDR_W-1:0] s_addr;
  logic [DATA_W-1:0] s_wdata;
  rd_tag_t           tag_in;
  rd_tag_t           tag_out;

  assign both  = en & rq.req0 & rq.req1;
  assign only0 = en & rq.req0 & ~rq.req1;
  assign only1 = en & ~rq.req0 & rq.req1;

  // grant decode and next arbiter state
  always_comb begin
    gnt0    = 1'b0;
    gnt1    = 1'b0;
    state_d = ARB_IDLE;
    unique case (1'b1)
      both: begin
        gnt0 = last_q;
        gnt1 = ~last_q;
      end
      only0:   gnt0 = 1'b1;
      only1:   gnt1 = 1'b1;
      default: ;
    endcase
    if (gnt0 | gnt1) begin
      state_d = ARB_ISSUE;
    end
  end

  assign xfer    = gnt0 | gnt1;
  assign win     = gnt1;
  assign rq.gnt0 = gnt0;
  assign rq.gnt1 = gnt1;

  assign s_we    = win ? rq.we1    : rq.we0;
  assign s_sel   = win ? rq.sel1   : rq.sel0;
  assign s_addr  = win ? rq.addr1  : rq.addr0;
  assign s_wdata = win ? rq.wdata1 : rq.wdata0;

  // arbiter state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ARB_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // capture the winning access onto the memory port
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_q   <= 1'b1;
      we_q     <= 1'b0;
      csel     <= CSEL_L0;
      caddr_wr <= '0;
      caddr_rd <= '0;
      cdata_wr <= '0;
    end else if (xfer) begin
      last_q <= win;
      we_q   <= s_we;
      csel   <= s_sel;
      if (s_we) begin
        caddr_wr <= s_addr;
        cdata_wr <= s_wdata;
      end else begin
        caddr_rd <= s_addr;
      end
    end
  end

  assign cwr = (state_q == ARB_ISSUE) & we_q;
  assign crd = (state_q == ARB_ISSUE) & ~we_q;

  assign tag_in.valid = xfer & ~s_we;
  assign tag_in.owner = win;

  lm_rd_tag_pipe #(
    .DEPTH (RD_LAT + 1)
  ) u_tag_pipe (
    .clk     (clk),
    .reset   (reset),
    .tag_in  (tag_in),
    .tag_out (tag_out)
  );

  // route returning read data to the tagged owner
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rq.rvalid0 <= 1'b0;
      rq.rvalid1 <= 1'b0;
      rq.rdata0  <= '0;
      rq.rdata1  <= '0;
    end else begin
      rq.rvalid0 <= tag_out.valid & ~tag_out.owner;
      rq.rvalid1 <= tag_out.valid & tag_out.owner;
      if (tag_out.valid) begin
        if (tag_out.owner) begin
          rq.rdata1 <= cdata_rd;
        end else begin
          rq.rdata0 <= cdata_rd;
        end
      end
    end
  end

`ifdef LM_ARB_STATS_EN
  // saturating grant and conflict statistics
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grant_cnt0   <= '0;
      grant_cnt1   <= '0;
      conflict_cnt <= '0;
    end else begin
      if (gnt0) begin
        grant_cnt0 <= sat_inc(grant_cnt0);
      end
      if (gnt1) begin
        grant_cnt1 <= sat_inc(grant_cnt1);
      end
      if (both) begin
        conflict_cnt <= sat_inc(conflict_cnt);
      end
    end
  end
`else
  assign grant_cnt0   = '0;
  assign grant_cnt1   = '0;
  assign conflict_cnt = '0;
`endif

endmodule

// File: tb/tb_layer_mem_arbiter.sv
// tb_layer_mem_arbiter: directed + randomized bench with a
// transaction-level reference model of the arbiter and memory.
module tb_layer_mem_arbiter;
  import lm_arb_pkg::*;

  localparam int RD_LAT = 1;

`ifdef LM_ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  typedef struct {
    bit                owner;
    logic [DATA_W-1:0] data;
    int                due;
  } exp_rd_t;

  logic              clk = 1'b0;
  logic              reset;
  logic              en;
  logic              cwr;
  logic              crd;
  logic              csel;
  logic [ADDR_W-1:0] caddr_wr;
  logic [ADDR_W-1:0] caddr_rd;
  logic [DATA_W-1:0] cdata_wr;
  logic [DATA_W-1:0] cdata_rd;
  logic [15:0]       grant_cnt0;
  logic [15:0]       grant_cnt1;
  logic [15:0]       conflict_cnt;

  layer_mem_arbiter_if rq();

  layer_mem_arbiter #(
    .RD_LAT (RD_LAT)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .en           (en),
    .rq           (rq),
    .cwr          (cwr),
    .crd          (crd),
    .caddr_wr     (caddr_wr),
    .caddr_rd     (caddr_rd),
    .cdata_wr     (cdata_wr),
    .cdata_rd     (cdata_rd),
    .csel         (csel),
    .grant_cnt0   (grant_cnt0),
    .grant_cnt1   (grant_cnt1),
    .conflict_cnt (conflict_cnt)
  );

  always #5 clk = ~clk;

  // layer memories: one-cycle registered read
  logic [DATA_W-1:0] env_mem [2][4096];
  logic [DATA_W-1:0] mem_q;

  always @(posedge clk) begin
    if (cwr) env_mem[csel][caddr_wr] <= cdata_wr;
    if (crd) mem_q <= env_mem[csel][caddr_rd];
  end
  assign cdata_rd = mem_q;

  // reference model state
  logic [DATA_W-1:0] ref_mem [2][4096];
  exp_rd_t           exp_q[$];
  bit                gseq[$];
  bit                lw;
  bit                m_cwr, m_crd, m_csel;
  logic [ADDR_W-1:0] m_caw, m_car;
  logic [DATA_W-1:0] m_cdw;
  int                m_gc0, m_gc1, m_conf;
  bit                last_g0, last_g1;
  int                cyc;
  int                n_rv0, n_rv1;
  int                ntot, npass;
  int                b0, b1;

  function automatic int sat16(input int v);
    return (v >= 65535) ? 65535 : v + 1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    exp_q.delete();
    lw = 1'b1;
    m_cwr = 0; m_crd = 0; m_csel = 0;
    m_caw = '0; m_car = '0; m_cdw = '0;
    m_gc0 = 0; m_gc1 = 0; m_conf = 0;
    last_g0 = 0; last_g1 = 0;
  endtask

  // one clock: check DUT against model, then advance the model
  task automatic tick();
    bit                eg0, eg1, w, we, sl;
    bit                rv0, rv1;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    exp_rd_t           e;
    @(negedge clk);
    eg0 = 0;
    eg1 = 0;
    if (en) begin
      if (rq.req0 && rq.req1) begin
        if (lw) eg0 = 1; else eg1 = 1;
      end else if (rq.req0) begin
        eg0 = 1;
      end else if (rq.req1) begin
        eg1 = 1;
      end
    end
    chk("gnt0", 32'(rq.gnt0), 32'(eg0));
    chk("gnt1", 32'(rq.gnt1), 32'(eg1));
    chk("cwr", 32'(cwr), 32'(m_cwr));
    chk("crd", 32'(crd), 32'(m_crd));
    chk("csel", 32'(csel), 32'(m_csel));
    chk("caddr_wr", 32'(caddr_wr), 32'(m_caw));
    chk("caddr_rd", 32'(caddr_rd), 32'(m_car));
    chk("cdata_wr", 32'(cdata_wr), 32'(m_cdw));
    rv0 = 0;
    rv1 = 0;
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      e = exp_q.pop_front();
      if (e.owner) begin
        rv1 = 1;
        chk("rdata1", 32'(rq.rdata1), 32'(e.data));
      end else begin
        rv0 = 1;
        chk("rdata0", 32'(rq.rdata0), 32'(e.data));
      end
    end
    chk("rvalid0", 32'(rq.rvalid0), 32'(rv0));
    chk("rvalid1", 32'(rq.rvalid1), 32'(rv1));
    chk("grant_cnt0", 32'(grant_cnt0), STATS ? m_gc0 : 0);
    chk("grant_cnt1", 32'(grant_cnt1), STATS ? m_gc1 : 0);
    chk("conflict_cnt", 32'(conflict_cnt), STATS ? m_conf : 0);
    if (rq.rvalid0 === 1'b1) n_rv0++;
    if (rq.rvalid1 === 1'b1) n_rv1++;
    if (rq.gnt0 === 1'b1 || rq.gnt1 === 1'b1) gseq.push_back(rq.gnt1);
    if (en && rq.req0 && rq.req1) m_conf = sat16(m_conf);
    m_cwr = 0;
    m_crd = 0;
    if (eg0 || eg1) begin
      w  = eg1;
      we = w ? rq.we1 : rq.we0;
      sl = w ? rq.sel1 : rq.sel0;
      a  = w ? rq.addr1 : rq.addr0;
      d  = w ? rq.wdata1 : rq.wdata0;
      m_cwr  = we;
      m_crd  = !we;
      m_csel = sl;
      if (we) begin
        ref_mem[sl][a] = d;
        m_caw = a;
        m_cdw = d;
      end else begin
        m_car = a;
        exp_q.push_back('{w, ref_mem[sl][a], cyc + RD_LAT + 2});
      end
      lw = w;
      if (w) m_gc1 = sat16(m_gc1);
      else m_gc0 = sat16(m_gc0);
    end
    last_g0 = eg0;
    last_g1 = eg1;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    logic [DATA_W-1:0] v;
    logic [ADDR_W-1:0] rd_addrs [4];
    ntot = 0; npass = 0; cyc = 0; n_rv0 = 0; n_rv1 = 0;
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 4096; i++) begin
        v = 13'($urandom);
        env_mem[s][i] = v;
        ref_mem[s][i] = v;
      end
    end
    env_mem[0][12'h040] = 13'h0AF0;
    ref_mem[0][12'h040] = 13'h0AF0;
    model_reset();
    reset = 0; en = 0;
    rq.req0 = 0; rq.req1 = 0; rq.we0 = 0; rq.we1 = 0;
    rq.sel0 = 0; rq.sel1 = 0; rq.addr0 = '0; rq.addr1 = '0;
    rq.wdata0 = '0; rq.wdata1 = '0;

    // reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cwr", 32'(cwr), 0);
    chk("rst_crd", 32'(crd), 0);
    chk("rst_csel", 32'(csel), 0);
    chk("rst_caddr_wr", 32'(caddr_wr), 0);
    chk("rst_caddr_rd", 32'(caddr_rd), 0);
    chk("rst_cdata_wr", 32'(cdata_wr), 0);
    chk("rst_rvalid0", 32'(rq.rvalid0), 0);
    chk("rst_rvalid1", 32'(rq.rvalid1), 0);
    chk("rst_rdata0", 32'(rq.rdata0), 0);
    chk("rst_rdata1", 32'(rq.rdata1), 0);
    chk("rst_conflict", 32'(conflict_cnt), 0);
    reset = 1;
    @(posedge clk);
    #1;

    // single write
    en = 1;
    rq.req0 = 1; rq.we0 = 1; rq.sel0 = 0;
    rq.addr0 = 12'h005; rq.wdata0 = 13'h0123;
    #1;
    chk("wr_gnt0", 32'(rq.gnt0), 1);
    tick();
    rq.req0 = 0;
    chk("wr_cwr", 32'(cwr), 1);
    chk("wr_csel", 32'(csel), 0);
    chk("wr_caddr", 32'(caddr_wr), 32'h005);
    chk("wr_cdata", 32'(cdata_wr), 32'h0123);
    tick();

    // single read with RD_LAT+1 return latency
    rq.req1 = 1; rq.we1 = 0; rq.sel1 = 0; rq.addr1 = 12'h040;
    #1;
    chk("rd_gnt1", 32'(rq.gnt1), 1);
    tick();
    rq.req1 = 0;
    chk("rd_crd", 32'(crd), 1);
    chk("rd_caddr", 32'(caddr_rd), 32'h040);
    tick();
    chk("rd_early", 32'(rq.rvalid1), 0);
    tick();
    chk("rd_rvalid1", 32'(rq.rvalid1), 1);
    chk("rd_rdata1", 32'(rq.rdata1), 32'h0AF0);
    tick();

    // conflict: alternation starting with requester 0
    gseq.delete();
    rq.req0 = 1; rq.we0 = 1; rq.sel0 = 1;
    rq.addr0 = 12'h010; rq.wdata0 = 13'h0555;
    rq.req1 = 1; rq.we1 = 0; rq.sel1 = 1; rq.addr1 = 12'h010;
    repeat (6) tick();
    chk("cf_conflict", 32'(conflict_cnt), STATS ? 6 : 0);
    rq.req0 = 0; rq.req1 = 0;
    chk("cf_len", 32'(gseq.size()), 6);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("cf_seq%0d", i), 32'(gseq[i]), 32'(i % 2));
    end
    repeat (3) tick();

    // read-after-write on the same L0 word
    rq.req0 = 1; rq.we0 = 1; rq.sel0 = 0;
    rq.addr0 = 12'h007; rq.wdata0 = 13'h1FFF;
    tick();
    rq.req0 = 0;
    rq.req1 = 1; rq.we1 = 0; rq.sel1 = 0; rq.addr1 = 12'h007;
    tick();
    rq.req1 = 0;
    tick();
    tick();
    chk("raw_rvalid1", 32'(rq.rvalid1), 1);
    chk("raw_rdata1", 32'(rq.rdata1), 32'h1FFF);
    tick();

    // back-to-back reads from requester 1
    b0 = n_rv0;
    b1 = n_rv1;
    rd_addrs[0] = 12'd0;
    rd_addrs[1] = 12'd1;
    rd_addrs[2] = 12'd64;
    rd_addrs[3] = 12'd65;
    rq.req1 = 1; rq.we1 = 0; rq.sel1 = 0;
    for (int i = 0; i < 4; i++) begin
      rq.addr1 = rd_addrs[i];
      tick();
    end
    rq.req1 = 0;
    repeat (3) tick();
    chk("b2b_rv1", 32'(n_rv1 - b1), 4);
    chk("b2b_rv0", 32'(n_rv0 - b0), 0);

    // en dropped with a read in flight
    rq.req0 = 1; rq.we0 = 0; rq.sel0 = 1; rq.addr0 = 12'h033;
    tick();
    en = 0;
    rq.req1 = 1; rq.we1 = 1; rq.addr1 = 12'h034;
    #1;
    chk("en0_gnt0", 32'(rq.gnt0), 0);
    chk("en0_gnt1", 32'(rq.gnt1), 0);
    repeat (3) tick();
    rq.req0 = 0; rq.req1 = 0; en = 1;
    tick();

    // reset one cycle after a read transfer
    rq.req1 = 1; rq.we1 = 0; rq.sel1 = 0; rq.addr1 = 12'h040;
    tick();
    rq.req1 = 0;
    chk("mr_crd_pre", 32'(crd), 1);
    b1 = n_rv1;
    reset = 0;
    #1;
    chk("mr_crd", 32'(crd), 0);
    chk("mr_cwr", 32'(cwr), 0);
    chk("mr_rvalid0", 32'(rq.rvalid0), 0);
    chk("mr_rvalid1", 32'(rq.rvalid1), 0);
    chk("mr_gcnt0", 32'(grant_cnt0), 0);
    chk("mr_gcnt1", 32'(grant_cnt1), 0);
    chk("mr_conflict", 32'(conflict_cnt), 0);
    model_reset();
    repeat (2) begin
      @(posedge clk);
      cyc++;
    end
    @(negedge clk);
    reset = 1;
    @(posedge clk);
    #1;
    cyc++;
    repeat (4) tick();
    chk("mr_no_rvalid", 32'(n_rv1 - b1), 0);

    // randomized traffic, honouring the hold-until-granted rule
    for (int k = 0; k < 400; k++) begin
      if (!(rq.req0 && !last_g0)) begin
        rq.req0   = 1'($urandom);
        rq.we0    = 1'($urandom);
        rq.sel0   = 1'($urandom);
        rq.addr0  = 12'($urandom_range(0, 15));
        rq.wdata0 = 13'($urandom);
      end
      if (!(rq.req1 && !last_g1)) begin
        rq.req1   = 1'($urandom);
        rq.we1    = 1'($urandom);
        rq.sel1   = 1'($urandom);
        rq.addr1  = 12'($urandom_range(0, 15));
        rq.wdata1 = 13'($urandom);
      end
      en = ($urandom_range(0, 4) != 0);
      tick();
    end
    rq.req0 = 0; rq.req1 = 0; en = 1;
    repeat (6) tick();

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
